// File: rtl/mem_access_stage.sv
// mem_access_stage
//   EX/MEM boundary of the 5-stage MIPS datapath. Registers the EX result,
//   runs word-wide LW/SW accesses to data memory over a req/ack handshake,
//   stalls EX (ex_ready low) while an access is outstanding, and presents a
//   registered writeback/forwarding bundle to WB and the EX forwarding mux.
//
//   Optional build macro: MEM_MISALIGN_TRAP_EN
//     defined   : LW/SW with a non-word-aligned address raise misalign_exc
//                 instead of accessing memory; wb_data carries the address.
//     undefined : misalign_exc is tied low; address bits [1:0] are dropped.
//
// Ports
//   clk, reset        stage clock, asynchronous active-high reset
//   ex_valid/ex_ready EX offer / stage can accept (ready only in IDLE)
//   flush             discard the instruction currently offered by EX
//   ex_*              EX result bundle (ALU result, store data, rd, ctrl)
//   dmem_*            data memory handshake (req held until ack)
//   wb_*              registered result bundle; wb_valid is a 1-cycle pulse,
//                     the other fields hold between pulses
//   misalign_exc      misaligned-access exception pulse (feature only)
module mem_access_stage #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ex_valid,
   output logic                  ex_ready,
   input  logic                  flush,
   input  logic [DATA_W-1:0]     ex_alu_result,
   input  logic [DATA_W-1:0]     ex_store_data,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_mem_read,
   input  logic                  ex_mem_write,
   input  logic                  ex_reg_write,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [DATA_W-1:0]     dmem_addr,
   output logic [DATA_W-1:0]     dmem_wdata,
   input  logic [DATA_W-1:0]     dmem_rdata,
   input  logic                  dmem_ack,
   output logic                  wb_valid,
   output logic                  wb_reg_write,
   output logic [REG_ADDR_W-1:0] wb_rd,
   output logic [DATA_W-1:0]     wb_data,
   output logic                  misalign_exc
);

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic                    accept;
   logic                    is_mem;
   logic                    misaligned;
   logic                    start_access;
   logic [REG_ADDR_W-1:0]   rd_p0;
   logic                    reg_write_p0;

   function automatic logic [DATA_W-1:0] word_align(input logic [DATA_W-1:0] addr);
      return {addr[DATA_W-1:2], 2'b00};
   endfunction

   assign ex_ready = (state == IDLE);
   assign accept   = ex_valid & ex_ready & ~flush;
   // Both mem_read and mem_write high behaves as a store (dmem_we follows mem_write).
   assign is_mem   = ex_mem_read | ex_mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
   assign misaligned = |ex_alu_result[1:0];
`else
   assign misaligned = 1'b0;
`endif

   assign start_access = accept & is_mem & ~misaligned;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_access) state_nxt = WAIT;
         WAIT:    if (dmem_ack)     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // EX/MEM boundary: memory request launch, completion and result bundle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dmem_req     <= 1'b0;
         dmem_we      <= 1'b0;
         dmem_addr    <= '0;
         dmem_wdata   <= '0;
         wb_valid     <= 1'b0;
         wb_reg_write <= 1'b0;
         wb_rd        <= '0;
         wb_data      <= '0;
         rd_p0        <= '0;
         reg_write_p0 <= 1'b0;
      end else begin
         wb_valid <= 1'b0;
         if (start_access) begin
            dmem_req     <= 1'b1;
            dmem_we      <= ex_mem_write;
            dmem_addr    <= word_align(ex_alu_result);
            dmem_wdata   <= ex_store_data;
            rd_p0        <= ex_rd;
            // Stores never write the register file.
            reg_write_p0 <= ex_reg_write & ~ex_mem_write;
         end else if (accept) begin
            // ALU result, or (trap build) a faulting memory op whose
            // address is reported in wb_data with the write suppressed.
            wb_valid     <= 1'b1;
            wb_rd        <= ex_rd;
            wb_data      <= ex_alu_result;
            wb_reg_write <= ex_reg_write & ~is_mem;
         end
         // flush is deliberately not consulted: an issued access always completes.
         if (state == WAIT && dmem_ack) begin
            dmem_req     <= 1'b0;
            wb_valid     <= 1'b1;
            wb_rd        <= rd_p0;
            wb_reg_write <= reg_write_p0;
            if (!dmem_we) wb_data <= dmem_rdata;
         end
      end
   end

`ifdef MEM_MISALIGN_TRAP_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) misalign_exc <= 1'b0;
      else       misalign_exc <= accept & is_mem & misaligned;
   end
`else
   assign misalign_exc = 1'b0;
`endif

endmodule
